uart_16550_tx: RTL and testbench

- Transmit serializer of the 16550-compatible UART.
- Sits directly downstream of the register file:
  - consumes THR writes (data register, offset 0x00) and the LCR byte (offset 0x0C);
  - is paced by the 16x baud enable from the divisor-latch baud generator;
  - drives the TxD pin.
- Returns the LSR THRE/TEMT status bits and a THRE-rise pulse for interrupt identification.

---
 rtl/uart_16550_tx.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_uart_16550_tx.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_16550_tx.sv
// -----------------------------------------------------------------------------
// uart_16550_tx
//
// Transmit serializer of a 16550-compatible UART. It takes THR writes and the
// LCR byte from the register file and shifts frames out on txd. Bit timing
// comes from the 16x baud enable. It returns the LSR THRE/TEMT status bits and
// a THRE-rise pulse for interrupt identification.
//
// Optional feature macro: UART_TX_FIFO_EN
//   undefined : 1-entry THR holding register (a write while full overwrites)
//   defined   : FIFO_DEPTH-entry transmit FIFO (a write while full is dropped)
//
// Ports:
//   clk          in   system clock
//   rst_n        in   asynchronous active-low reset
//   baud_tick16  in   single-cycle enable, 16 per bit time
//   lcr[7:0]     in   line control: [1:0] length-5, [2] stop, [3] PEN,
//                     [4] EPS, [5] stick, [6] break, [7] DLAB (unused)
//   thr_wr       in   THR write strobe
//   thr_wdata    in   byte written to THR
//   tx_clr       in   FCR[2] pulse, discards pending (not yet loaded) data
//   txd          out  serial output, idle high
//   thre         out  LSR[5], holding register / FIFO empty
//   temt         out  LSR[6], holding empty and shifter idle
//   thre_rise    out  one-cycle pulse, the cycle after thre goes 0->1
//
// Write interface: thr_wr is a one-cycle strobe with no ready/back-pressure.
// A byte is taken on every clock edge where thr_wr=1 and tx_clr=0. When there
// is no free slot, the byte overwrites the THR (no FIFO) or is dropped (FIFO).
// -----------------------------------------------------------------------------
module uart_16550_tx #(
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       baud_tick16,
    input  logic [7:0] lcr,
    input  logic       thr_wr,
    input  logic [7:0] thr_wdata,
    input  logic       tx_clr,
    output logic       txd,
    output logic       thre,
    output logic       temt,
    output logic       thre_rise
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic [7:0] w_shift_nxt;
    logic [3:0] r_cfg;          // frame config latched at load: [1:0] len, [2] stop, [3] PEN
    logic       r_par;          // parity bit value, computed once at load
    logic       r_txd;
    logic       w_txd_nxt;
    logic       r_thre_q;
    logic       r_thre_rise;

    logic       w_hold_valid;
    logic [7:0] w_hold_data;
    logic       w_load;         // shifter takes the head of the holding stage
    logic       w_unused;

    // -------------------------------------------------------------------------
    // Holding stage
    // -------------------------------------------------------------------------
`ifdef UART_TX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [CW-1:0] r_count;
    logic          w_full;
    logic          w_push;

    assign w_full = (r_count == CW'(FIFO_DEPTH));
    // When full, a push is still accepted if the head is popped on the same
    // edge; the slot being written is the one just read out.
    assign w_push = thr_wr && !tx_clr && (!w_full || w_load);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (tx_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_load);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= thr_wdata;
        end
    end

    assign w_hold_valid = (r_count != '0);
    assign w_hold_data  = r_mem[r_rptr];
    assign w_unused     = lcr[7];
`else
    logic       r_hold_valid;
    logic [7:0] r_hold_data;

    // Clear beats write; a write on the load edge refills the freed slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold_valid <= 1'b0;
            r_hold_data  <= '0;
        end else if (tx_clr) begin
            r_hold_valid <= 1'b0;
        end else if (thr_wr) begin
            r_hold_valid <= 1'b1;
            r_hold_data  <= thr_wdata;
        end else if (w_load) begin
            r_hold_valid <= 1'b0;
        end
    end

    assign w_hold_valid = r_hold_valid;
    assign w_hold_data  = r_hold_data;
    assign w_unused     = ^{lcr[7], 32'(FIFO_DEPTH)};
`endif

    // -------------------------------------------------------------------------
    // Bit timing
    // -------------------------------------------------------------------------
    logic       w_bit_done;
    logic       w_stop_done;
    logic [2:0] w_last_bit;
    logic [7:0] w_len_mask;
    logic       w_par_load;

    assign w_bit_done = baud_tick16 && (r_tick_cnt == 4'd15);
    assign w_last_bit = 3'd4 + {1'b0, r_cfg[1:0]};

    // Long stop bits span two 16-tick periods; r_bit_cnt counts the completed
    // periods inside STOP, so 24 ticks ends at period 1 tick 7 and 32 at
    // period 1 tick 15.
    always_comb begin
        w_stop_done = 1'b0;
        if (!r_cfg[2]) begin
            w_stop_done = w_bit_done;
        end else if (r_cfg[1:0] == 2'd0) begin
            w_stop_done = baud_tick16 && (r_bit_cnt == 3'd1) && (r_tick_cnt == 4'd7);
        end else begin
            w_stop_done = baud_tick16 && (r_bit_cnt == 3'd1) && (r_tick_cnt == 4'd15);
        end
    end

    // Parity is taken from the live lcr at load time, over the N data bits.
    always_comb begin
        w_len_mask = 8'hFF;
        case (lcr[1:0])
            2'd0:    w_len_mask = 8'h1F;
            2'd1:    w_len_mask = 8'h3F;
            2'd2:    w_len_mask = 8'h7F;
            default: w_len_mask = 8'hFF;
        endcase
    end

    assign w_par_load = lcr[5] ? ~lcr[4] : ((^(w_hold_data & w_len_mask)) ^ ~lcr[4]);

    // -------------------------------------------------------------------------
    // FSM: next state, shift register and registered txd value
    // -------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_shift_nxt = r_shift;
        w_txd_nxt   = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (w_hold_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_bit_done) begin
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_done) begin
                    if (r_bit_cnt == w_last_bit) begin
                        w_state_nxt = r_cfg[3] ? S_PARITY : S_STOP;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                    end
                end
            end
            S_PARITY: begin
                if (w_bit_done) begin
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_stop_done) begin
                    if (w_hold_valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_load) begin
            w_shift_nxt = w_hold_data;
        end

        // txd is registered, so it follows the state being entered.
        case (w_state_nxt)
            S_START:  w_txd_nxt = 1'b0;
            S_DATA:   w_txd_nxt = w_shift_nxt[0];
            S_PARITY: w_txd_nxt = r_par;
            default:  w_txd_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_cfg      <= '0;
            r_par      <= 1'b0;
            r_txd      <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_txd   <= w_txd_nxt;

            if (w_load || (w_state_nxt != r_state)) begin
                r_tick_cnt <= '0;
            end else if (baud_tick16) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end

            if (w_state_nxt != r_state) begin
                r_bit_cnt <= '0;
            end else if (w_bit_done && (r_state == S_DATA || r_state == S_STOP)) begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end

            if (w_load) begin
                r_cfg <= lcr[3:0];
                r_par <= w_par_load;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Status
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_thre_q    <= 1'b1;
            r_thre_rise <= 1'b0;
        end else begin
            r_thre_q    <= thre;
            r_thre_rise <= thre && !r_thre_q;
        end
    end

    assign thre      = !w_hold_valid;
    assign temt      = thre && (r_state == S_IDLE);
    assign thre_rise = r_thre_rise;
    // Break overrides the line without stopping the FSM.
    assign txd       = r_txd & ~lcr[6];

endmodule

// File: tb/tb_uart_16550_tx.sv
module tb_uart_16550_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick16 = 1'b0;
  logic [7:0] lcr = 8'h03;
  logic       thr_wr = 1'b0;
  logic [7:0] thr_wdata = 8'h00;
  logic       tx_clr = 1'b0;
  logic       txd;
  logic       thre;
  logic       temt;
  logic       thre_rise;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int tick_mode = 0;   // 0: no ticks, 1: tick every cycle, 2: random ticks
  int t_start = 0;

  // scoreboard: expected per-tick line image of each frame, bit 0 = first tick
  logic [191:0] exp_q[$];
  int           exp_len_q[$];

  logic         mon_en = 1'b1;
  logic         mon_active = 1'b0;
  int           mon_idx = 0;
  int           mon_len = 0;
  int           mon_gap = 0;
  int           mon_last_gap = 0;
  int           frames_seen = 0;
  int           rise_cnt = 0;
  int           rise_cyc = 0;
  logic [191:0] mon_rx;
  logic [191:0] mon_exp;

  uart_16550_tx #(.FIFO_DEPTH(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .baud_tick16 (baud_tick16),
    .lcr         (lcr),
    .thr_wr      (thr_wr),
    .thr_wdata   (thr_wdata),
    .tx_clr      (tx_clr),
    .txd         (txd),
    .thre        (thre),
    .temt        (temt),
    .thre_rise   (thre_rise)
  );

  // ---------------- clock / reset / tick generation ----------------
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #2;
    case (tick_mode)
      0:       baud_tick16 = 1'b0;
      1:       baud_tick16 = 1'b1;
      default: baud_tick16 = ($urandom_range(0, 3) == 0);
    endcase
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Line image of one frame in baud ticks, straight from the frame rules.
  function automatic void build_frame(input logic [7:0] d, input logic [7:0] l,
                                      output logic [191:0] v, output int len);
    int   n;
    int   stop_t;
    logic p;
    n   = 5 + int'(l[1:0]);
    v   = '0;
    len = 16;
    p   = 1'b0;
    for (int i = 0; i < n; i++) begin
      p = p ^ d[i];
      for (int k = 0; k < 16; k++) begin
        v[len] = d[i];
        len++;
      end
    end
    if (l[3]) begin
      if (l[5]) p = ~l[4];
      else if (!l[4]) p = ~p;
      for (int k = 0; k < 16; k++) begin
        v[len] = p;
        len++;
      end
    end
    stop_t = !l[2] ? 16 : ((n == 5) ? 24 : 32);
    for (int k = 0; k < stop_t; k++) begin
      v[len] = 1'b1;
      len++;
    end
  endfunction

  task automatic enqueue(input logic [7:0] d, input logic [7:0] l);
    logic [191:0] v;
    int           len;
    build_frame(d, l, v, len);
    exp_q.push_back(v);
    exp_len_q.push_back(len);
  endtask

  // ---------------- line monitor ----------------
  always @(negedge clk) begin
    if (thre_rise) begin
      rise_cnt++;
      rise_cyc = cyc;
    end
    if (!rst_n || !mon_en) begin
      mon_active = 1'b0;
      mon_gap    = 0;
    end else if (baud_tick16) begin
      if (!mon_active) begin
        if (txd == 1'b0) begin
          mon_active   = 1'b1;
          mon_rx       = '0;
          mon_idx      = 1;
          mon_last_gap = mon_gap;
          mon_gap      = 0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", 192'(exp_q.size() + 1), 192'(0));
            mon_exp = '0;
            mon_len = 16;
          end else begin
            mon_exp = exp_q.pop_front();
            mon_len = exp_len_q.pop_front();
          end
        end else begin
          mon_gap++;
        end
      end else begin
        mon_rx[mon_idx] = txd;
        mon_idx++;
        if (mon_idx == mon_len) begin
          check("frame_bits", mon_rx, mon_exp);
          mon_active = 1'b0;
          frames_seen++;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic write_thr(input logic [7:0] d);
    thr_wr    = 1'b1;
    thr_wdata = d;
    step();
    thr_wr    = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (txd !== 1'b0 && i < 5000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 5000) check({tag, "_start_timeout"}, 192'(txd), 192'(0));
  endtask

  task automatic wait_temt(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (temt !== 1'b1 && i < 8000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 8000) check({tag, "_temt_timeout"}, 192'(temt), 192'(1));
  endtask

  task automatic wait_thre(input string tag);
    int i;
    i = 0;
    @(negedge clk);
    while (thre !== 1'b1 && i < 8000) begin
      @(negedge clk);
      i++;
    end
    if (i >= 8000) check({tag, "_thre_timeout"}, 192'(thre), 192'(1));
  endtask

  // One frame with ticks every cycle; checks frame duration via temt.
  task automatic send_timed(input string tag, input logic [7:0] l, input logic [7:0] d,
                            input logic do_mid, input logic [7:0] mid_l);
    logic [191:0] v;
    int           len;
    lcr = l;
    step();
    build_frame(d, l, v, len);
    enqueue(d, l);
    write_thr(d);
    wait_start(tag);
    t_start = cyc;
    if (do_mid) begin
      repeat (50) step();
      lcr = mid_l;
    end
    wait_temt(tag);
    check(tag, 192'(cyc - t_start), 192'(len));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int           f0;
    int           nb;
    logic [7:0]   d;

    tick_mode = 1;
    repeat (3) @(negedge clk);
    check("rst_txd", 192'(txd), 192'(1));
    check("rst_thre", 192'(thre), 192'(1));
    check("rst_temt", 192'(temt), 192'(1));
    check("rst_rise", 192'(thre_rise), 192'(0));
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // idle with ticks running: line stays quiet
    repeat (60) step();
    @(negedge clk);
    check("idle_txd", 192'(txd), 192'(1));
    check("idle_thre", 192'(thre), 192'(1));
    check("idle_temt", 192'(temt), 192'(1));
    check("idle_no_rise", 192'(rise_cnt), 192'(0));

    // 8N1 0x55: 160-tick frame, thre_rise right after the load
    send_timed("lat_8n1", 8'h03, 8'h55, 1'b0, 8'h00);
    check("rise_lat", 192'(rise_cyc - t_start), 192'(1));

    // parity variants
    send_timed("lat_8e1", 8'h1B, 8'h07, 1'b0, 8'h00);
    send_timed("lat_8o1", 8'h0B, 8'h07, 1'b0, 8'h00);
    send_timed("lat_stick", 8'h2B, 8'h07, 1'b0, 8'h00);
    send_timed("lat_7e1", 8'h1A, 8'hFF, 1'b0, 8'h00);

    // stop lengths, and a mid-frame lcr change that must not affect the frame
    send_timed("lat_5n15", 8'h04, 8'h1F, 1'b0, 8'h00);
    send_timed("lat_8n2", 8'h07, 8'h96, 1'b0, 8'h00);
    send_timed("lat_8n2_mid", 8'h07, 8'hC3, 1'b1, 8'h03);

    // back-to-back frames: second write lands during the first frame's DATA
    lcr = 8'h03;
    step();
    f0 = frames_seen;
    enqueue(8'hA5, lcr);
    write_thr(8'hA5);
    wait_start("b2b");
    repeat (30) step();
    enqueue(8'h3C, lcr);
    write_thr(8'h3C);
    wait_temt("b2b");
    check("b2b_gap", 192'(mon_last_gap), 192'(0));
    check("b2b_frames", 192'(frames_seen - f0), 192'(2));

    // second write while busy: overwrite without FIFO, queued with FIFO
    enqueue(8'h81, lcr);
    write_thr(8'h81);
    wait_start("ovw");
`ifdef UART_TX_FIFO_EN
    enqueue(8'h11, lcr);
`endif
    write_thr(8'h11);
    enqueue(8'h22, lcr);
    write_thr(8'h22);
    wait_temt("ovw");

    // tx_clr drops the pending byte (and a simultaneous write), frame continues
    enqueue(8'h3A, lcr);
    write_thr(8'h3A);
    wait_start("clr");
    write_thr(8'h42);
    check("clr_pre_thre", 192'(thre), 192'(0));
    thr_wr    = 1'b1;
    thr_wdata = 8'h99;
    tx_clr    = 1'b1;
    step();
    thr_wr    = 1'b0;
    tx_clr    = 1'b0;
    check("clr_thre", 192'(thre), 192'(1));
    wait_temt("clr");

`ifdef UART_TX_FIFO_EN
    // FIFO fill while the shifter is stalled in START (no ticks)
    tick_mode = 0;
    step();
    f0 = frames_seen;
    enqueue(8'h01, lcr);
    write_thr(8'h01);
    repeat (3) step();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) enqueue(8'(8'h10 + i), lcr);
      thr_wr    = 1'b1;
      thr_wdata = 8'(8'h10 + i);
      step();
    end
    thr_wr = 1'b0;
    check("fifo_full_thre", 192'(thre), 192'(0));
    tick_mode = 1;
    wait_temt("fifo");
    check("fifo_frames", 192'(frames_seen - f0), 192'(17));
`endif

    // break: line forced low at once, frame runs on underneath
    mon_en = 1'b0;
    lcr = 8'h03;
    step();
    write_thr(8'hFF);
    wait_start("brk");
    repeat (40) step();
    check("brk_pre_txd", 192'(txd), 192'(1));
    lcr = 8'h43;
    #1;
    check("brk_txd", 192'(txd), 192'(0));
    wait_temt("brk");
    lcr = 8'h03;
    step();
    check("brk_release_txd", 192'(txd), 192'(1));

    // reset mid-DATA with a byte pending
    write_thr(8'hF0);
    wait_start("rst");
    repeat (40) step();
    write_thr(8'h12);
    check("rst_pre_txd", 192'(txd), 192'(0));
    check("rst_pre_thre", 192'(thre), 192'(0));
    rst_n = 1'b0;
    #1;
    check("rst_mid_txd", 192'(txd), 192'(1));
    check("rst_mid_thre", 192'(thre), 192'(1));
    check("rst_mid_temt", 192'(temt), 192'(1));
    step();
    rst_n = 1'b1;
    repeat (250) step();
    check("rst_post_txd", 192'(txd), 192'(1));
    check("rst_post_temt", 192'(temt), 192'(1));
    mon_en = 1'b1;
    step();

    // randomized traffic with random tick spacing
    tick_mode = 2;
    for (int g = 0; g < 10; g++) begin
      lcr = {2'b00, 6'($urandom_range(0, 63))};
      step();
      nb = $urandom_range(1, 3);
      for (int b = 0; b < nb; b++) begin
        wait_thre("rnd");
        d = 8'($urandom_range(0, 255));
        enqueue(d, lcr);
        write_thr(d);
      end
      wait_temt("rnd");
    end
    repeat (5) step();

    check("exp_q_empty", 192'(exp_q.size()), 192'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
